spi_master_mu: RTL and testbench

FPGA-side SPI master that issues 40-bit frames in the same format our FPGA SPI slave accepts: an 8-bit header, either write flag + 4-bit address or read + 4-bit address, followed by 32 data bits. It lets on-board logic drive a slave FPGA, or a loopback test fixture, with the same register-slot protocol the Raspberry Pi uses. A simple start/done handshake sits on the core side; SPI pins go to the top level.

---
 rtl/spi_master_mu_pkg.sv | 30 +++
 rtl/spi_master_mu_if.sv | 19 +
 rtl/spi_master_mu_sync2.sv | 22 ++
 rtl/spi_master_mu.sv | 132 +++++++++++++
 tb/tb_spi_master_mu.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_mu_pkg.sv
// spi_mu_pkg -- shared definitions for the 40-bit register-slot SPI frame.
// A frame is an 8-bit header {wr, 3'b000, addr[3:0]} followed by 32 data
// bits, MSB first. The FPGA-side slave uses the same constants.
// Contents: frame geometry constants, the master FSM state type and a
// helper that assembles a transmit frame.
package spi_mu_pkg;

  localparam int FRAME_BITS = 40;
  localparam int HDR_BITS   = 8;
  localparam int ADDR_BITS  = 4;
  localparam int WR_BIT     = 7;
  localparam int DATA_BITS  = FRAME_BITS - HDR_BITS;
  localparam int BIT_CNT_W  = 6;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  // Read frames carry zeros in the data field; the slave drives MISO then.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 wr,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] wdata
  );
    logic [HDR_BITS-1:0] hdr;
    hdr                  = '0;
    hdr[WR_BIT]          = wr;
    hdr[ADDR_BITS-1:0]   = addr;
    return {hdr, (wr ? wdata : {DATA_BITS{1'b0}})};
  endfunction

endpackage

// File: rtl/spi_master_mu_if.sv
// spi_master_mu_if -- core-side start/done handshake of the SPI master.
// Signals: start, wr, addr[3:0], wdata[31:0] (core -> master);
//          busy, done, rdata[31:0] (master -> core).
// Modports: master = requesting core logic, slave = the SPI master block.
interface spi_master_mu_if;
  import spi_mu_pkg::*;

  logic                 start;
  logic                 wr;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] rdata;

  modport master (output start, wr, addr, wdata, input busy, done, rdata);
  modport slave  (input start, wr, addr, wdata, output busy, done, rdata);

endinterface

// File: rtl/spi_master_mu_sync2.sv
// sync2 -- generic two-flop synchronizer with asynchronous active-high reset.
// Ports: clk, reset, d (asynchronous input), q (synchronized output, resets 0).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_master_mu.sv
// spi_master_mu -- SPI mode-0 master issuing 40-bit register-slot frames.
// Parameter: CLK_DIV -- SPI half-period in clk cycles (>= 4).
// Ports: clk, reset (async, active-high);
//        bus (spi_master_mu_if.slave): start/wr/addr/wdata in, busy/done/rdata out;
//        SPI_CLK, SPI_CS (active low), SPI_MOSI out; SPI_MISO in.
// Build option: define SPI_MASTER_MISO_SYNC_EN to pass SPI_MISO through a
// two-flop synchronizer before sampling. Frame timing is the same either way.
module spi_master_mu
  import spi_mu_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_mu_if.slave    bus,
  output logic              SPI_CLK,
  output logic              SPI_CS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] HDR_LAST = BIT_CNT_W'(HDR_BITS);

  state_t                 state, state_n;
  logic [PH_W-1:0]        phase;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [FRAME_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0]   rx_sr;
  logic                   is_rd;
  logic                   miso_s;
  logic                   ph_last;
  logic                   busy_n, done_n, cs_n, sclk_n;

`ifdef SPI_MASTER_MISO_SYNC_EN
  sync2 u_miso_sync (
    .clk   (clk),
    .reset (reset),
    .d     (SPI_MISO),
    .q     (miso_s)
  );
`else
  assign miso_s = SPI_MISO;
`endif

  assign ph_last  = (phase == PH_LAST);
  // MOSI comes straight off the top shift-register flop.
  assign SPI_MOSI = tx_sr[FRAME_BITS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Outputs are decoded from the next state and registered below, so every
  // pin changes on the same edge as the state it belongs to.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_n = SETUP;
      SETUP: if (ph_last)   state_n = HIGH;
      HIGH:  if (ph_last)   state_n = LOW;
      LOW: begin
        if (ph_last) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = GAP;
            done_n  = 1'b1;
          end else begin
            state_n = HIGH;
          end
        end
      end
      GAP:     if (ph_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    cs_n   = !(state_n == SETUP || state_n == HIGH || state_n == LOW);
    sclk_n = (state_n == HIGH);
  end

  // ---- registered datapath and pins ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_rd     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
      SPI_CS    <= 1'b1;
      SPI_CLK   <= 1'b0;
    end else begin
      bus.busy <= busy_n;
      bus.done <= done_n;
      SPI_CS   <= cs_n;
      SPI_CLK  <= sclk_n;
      phase    <= (state == IDLE || state_n != state) ? '0 : phase + 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx_sr   <= build_frame(bus.wr, bus.addr, bus.wdata);
            is_rd   <= !bus.wr;
            bit_cnt <= '0;
          end
        end
        SETUP: if (ph_last) bit_cnt <= BIT_CNT_W'(1);
        HIGH: begin
          if (ph_last) begin
            // Header bits 1..8 are don't-care on MISO.
            if (bit_cnt > HDR_LAST) rx_sr <= {rx_sr[DATA_BITS-2:0], miso_s};
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
          end
        end
        LOW: begin
          if (ph_last) begin
            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
            else if (is_rd)          bus.rdata <= rx_sr;
          end
        end
        GAP:     ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mu.sv
// tb_spi_master_mu -- self-checking bench for spi_master_mu (CLK_DIV = 4).
// Table-driven directed frames, randomized frames against a frame-level
// reference model, reset mid-frame and back-to-back start sequences.
// A negedge monitor captures MOSI at SPI_CLK rises, measures pulse widths,
// CS/busy durations and acts as a slave returning a response word from
// bit 9 onward with a few cycles of delay after each falling edge.
module tb_spi_master_mu;
  import spi_mu_pkg::*;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic spi_clk, spi_cs, spi_mosi;
  logic spi_miso = 1'b0;

  spi_master_mu_if bus ();

  spi_master_mu #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .SPI_CLK  (spi_clk),
    .SPI_CS   (spi_cs),
    .SPI_MOSI (spi_mosi),
    .SPI_MISO (spi_miso)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / slave model state ----------------
  logic [31:0] slave_resp = 32'h0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
  logic        miso_raw = 1'b0, miso_d1 = 1'b0;
  int          cs_run = 0, sclk_run = 0, rises = 0, clk_bad = 0, first_rise = -1;
  int          busy_run = 0, busy_len = 0, gap_run = 0, gap_min = 1000000;
  logic [39:0] mosi_cap = '0;
  int          fr_count = 0, fr_cs_len = 0, fr_rises = 0, fr_clk_bad = 0, fr_first_rise = 0;
  logic [39:0] fr_mosi = '0;
  int          done_cnt = 0;
  logic [31:0] done_rdata = '0;
  logic        done_cs = 1'b0;

  task automatic monitor_step();
    // slave: next bit goes out after each falling edge, delayed two stages
    if (!spi_cs && prev_sclk && !spi_clk) begin
      if (rises >= 8 && rises < 40) miso_raw = slave_resp[31 - (rises - 8)];
      else                          miso_raw = 1'($urandom_range(0, 1));
    end
    spi_miso = miso_d1;
    miso_d1  = miso_raw;

    if (prev_cs && !spi_cs) begin
      if (fr_count > 0 && gap_run < gap_min) gap_min = gap_run;
      cs_run = 0; rises = 0; mosi_cap = '0; clk_bad = 0; first_rise = -1; sclk_run = 0;
    end
    if (!spi_cs) begin
      cs_run++;
      if (!prev_sclk && spi_clk) begin
        rises++;
        mosi_cap = {mosi_cap[38:0], spi_mosi};
        if (rises == 1) first_rise = cs_run - 1;
        else if (sclk_run != CLK_DIV) clk_bad++;
        sclk_run = 1;
      end else if (prev_sclk && !spi_clk) begin
        if (sclk_run != CLK_DIV) clk_bad++;
        sclk_run = 1;
      end else begin
        sclk_run++;
      end
    end
    if (!prev_cs && spi_cs) begin
      if (sclk_run != CLK_DIV) clk_bad++;
      fr_cs_len = cs_run; fr_rises = rises; fr_clk_bad = clk_bad;
      fr_first_rise = first_rise; fr_mosi = mosi_cap;
      fr_count++;
      gap_run = 0;
    end
    if (spi_cs) gap_run++;

    if (!prev_busy && bus.busy) busy_run = 0;
    if (bus.busy) busy_run++;
    if (prev_busy && !bus.busy) busy_len = busy_run;

    if (bus.done) begin
      done_cnt++;
      done_rdata = bus.rdata;
      done_cs    = spi_cs;
    end

    prev_cs   = spi_cs;
    prev_sclk = spi_clk;
    prev_busy = bus.busy;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  // read monitor results only after it has run for this negedge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_rdata = 32'h0;

  function automatic logic [39:0] model_frame(input logic wr, input logic [3:0] addr,
                                              input logic [31:0] wdata);
    logic [39:0] f;
    f = 40'(addr) * 40'h1_0000_0000;
    if (wr) f = f + 40'h80_0000_0000 + 40'(wdata);
    return f;
  endfunction

  task automatic run_and_check(input string name, input logic wr, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic [31:0] resp,
                               input logic [39:0] exp_frame, input logic [31:0] exp_rdata);
    int guard;
    int d0;
    slave_resp = resp;
    guard = 0;
    while (bus.busy && guard < 2000) begin tick(); guard++; end
    d0 = done_cnt;
    bus.wr = wr; bus.addr = addr; bus.wdata = wdata; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 1000) begin tick(); guard++; end
    check({name, " done_seen"}, done_cnt != d0, 1);
    check({name, " rdata_at_done"}, done_rdata, exp_rdata);
    check({name, " cs_high_at_done"}, done_cs, 1);
    repeat (CLK_DIV + 4) tick();
    check({name, " mosi_frame"}, fr_mosi, exp_frame);
    check({name, " sclk_pulses"}, fr_rises, 40);
    check({name, " cs_low_cycles"}, fr_cs_len, 81 * CLK_DIV);
    check({name, " busy_cycles"}, busy_len, 82 * CLK_DIV);
    check({name, " first_rise"}, fr_first_rise, CLK_DIV);
    check({name, " sclk_width_errs"}, fr_clk_bad, 0);
    check({name, " done_pulses"}, done_cnt - d0, 1);
    check({name, " rdata_after"}, bus.rdata, exp_rdata);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic [39:0] exp_frame;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, d0, f0;
    logic        r_wr;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata, r_resp;

    vecs[0] = '{1'b1, 4'h8, 32'hDEADBEEF, 32'hFFFF_FFFF, 40'h88DEADBEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 4'h1, 32'hCAFEF00D, 32'h1234_5678, 40'h0100000000, 32'h1234_5678};
    vecs[2] = '{1'b1, 4'h3, 32'h0000_0000, 32'h5555_AAAA, 40'h8300000000, 32'h1234_5678};
    vecs[3] = '{1'b0, 4'hF, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 40'h0F00000000, 32'hA5A5_0F0F};
    vecs[4] = '{1'b0, 4'h0, 32'h1357_9BDF, 32'h0000_0000, 40'h0000000000, 32'h0000_0000};
    vecs[5] = '{1'b1, 4'h7, 32'hFFFF_FFFF, 32'h8000_0001, 40'h87FFFFFFFF, 32'h0000_0000};

    bus.start = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst cs", spi_cs, 1);
    check("rst sclk", spi_clk, 0);
    check("rst mosi", spi_mosi, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst rdata", bus.rdata, 0);

    // directed table
    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].resp, vecs[i].exp_frame, vecs[i].exp_rdata);
      model_rdata = vecs[i].exp_rdata;
    end

    // randomized frames against the model
    for (int i = 0; i < 10; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = 4'($urandom_range(0, 15));
      r_wdata = $urandom;
      r_resp  = $urandom;
      if (!r_wr) model_rdata = r_resp;
      run_and_check($sformatf("rnd%0d", i), r_wr, r_addr, r_wdata, r_resp,
                    model_frame(r_wr, r_addr, r_wdata), model_rdata);
    end

    // reset in the middle of a read frame
    slave_resp = 32'h0BAD_F00D;
    d0 = done_cnt;
    bus.wr = 1'b0; bus.addr = 4'h9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (rises < 20 && guard < 1000) begin tick(); guard++; end
    check("midrst reached_bit20", rises >= 20, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst cs", spi_cs, 1);
    check("midrst sclk", spi_clk, 0);
    check("midrst mosi", spi_mosi, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst rdata", bus.rdata, 0);
    repeat (3) tick();
    reset = 1'b0;
    model_rdata = 32'h0;
    repeat (20) tick();
    check("midrst no_done", done_cnt - d0, 0);
    check("midrst idle_busy", bus.busy, 0);
    run_and_check("post_rst", 1'b0, 4'h2, 32'h0, 32'h7E57_1234,
                  model_frame(1'b0, 4'h2, 32'h0), 32'h7E57_1234);
    model_rdata = 32'h7E57_1234;

    // start held high: frames back to back, no extras while busy
    f0 = fr_count;
    d0 = done_cnt;
    gap_min = 1000000;
    bus.wr = 1'b1; bus.addr = 4'h2; bus.wdata = 32'h0F1E_2D3C; bus.start = 1'b1;
    repeat (800) tick();
    bus.start = 1'b0;
    guard = 0;
    while (bus.busy && guard < 2000) begin tick(); guard++; end
    repeat (4) tick();
    check("b2b frames", fr_count - f0, 3);
    check("b2b done_pulses", done_cnt - d0, 3);
    check("b2b cs_gap_ge_div", gap_min >= CLK_DIV, 1);
    check("b2b last_frame", fr_mosi, model_frame(1'b1, 4'h2, 32'h0F1E_2D3C));
    check("b2b rdata_kept", bus.rdata, model_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
